// File: rtl/fetch_pc_ctrl_if.sv
// rtl/fetch_pc_ctrl_if.sv - fetch-stage bus: PC to imem, decoded fields back, F/D register out
//
// Purpose: groups every non-clock signal of fetch_pc_ctrl.
// Ports (signals):
//   f_pc                         current fetch PC to instruction memory
//   im_icode/ifun/rA/rB/valC     fields returned combinationally for f_pc
//   stall_f, stall_d, bubble_d   pipeline control
//   mispredict, mispredict_pc    not-taken correction for a predicted-taken jXX
//   ret_valid, ret_pc            return address from writeback
//   d_icode/ifun/rA/rB/valC/valP F/D register contents
//   d_stat, d_valid              status (1 AOK, 2 HLT, 3 ADR, 4 INS) and bubble flag
// Modports: master = fetch controller, slave = surrounding pipeline/memory.
interface fetch_pc_ctrl_if #(
  parameter int DATA_WID = 64
);
  logic [DATA_WID-1:0] f_pc;
  logic [3:0]          im_icode;
  logic [3:0]          im_ifun;
  logic [3:0]          im_rA;
  logic [3:0]          im_rB;
  logic [DATA_WID-1:0] im_valC;
  logic                stall_f;
  logic                stall_d;
  logic                bubble_d;
  logic                mispredict;
  logic [DATA_WID-1:0] mispredict_pc;
  logic                ret_valid;
  logic [DATA_WID-1:0] ret_pc;
  logic [3:0]          d_icode;
  logic [3:0]          d_ifun;
  logic [3:0]          d_rA;
  logic [3:0]          d_rB;
  logic [DATA_WID-1:0] d_valC;
  logic [DATA_WID-1:0] d_valP;
  logic [2:0]          d_stat;
  logic                d_valid;

  modport master (
    output f_pc,
    input  im_icode, im_ifun, im_rA, im_rB, im_valC,
    input  stall_f, stall_d, bubble_d,
    input  mispredict, mispredict_pc, ret_valid, ret_pc,
    output d_icode, d_ifun, d_rA, d_rB, d_valC, d_valP, d_stat, d_valid
  );

  modport slave (
    input  f_pc,
    output im_icode, im_ifun, im_rA, im_rB, im_valC,
    output stall_f, stall_d, bubble_d,
    output mispredict, mispredict_pc, ret_valid, ret_pc,
    input  d_icode, d_ifun, d_rA, d_rB, d_valC, d_valP, d_stat, d_valid
  );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// rtl/fetch_pc_ctrl.sv - Y86-64 fetch-stage PC controller and F/D pipeline register
//
// Purpose: owns the PC, sizes the fetched instruction, predicts the next PC,
// loads the F/D register and tracks RUN/RET_WAIT/HALT/ERR state.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   bus      fetch_pc_ctrl_if.master (see interface file for signal list)
// Optional feature macro: INSTR_VALID_CHECK_EN (icode > 0xB loads with INS and
// stops fetch; when undefined such codes behave as 1-byte nops).
module fetch_pc_ctrl #(
  parameter int                  DATA_WID   = 64,
  parameter logic [DATA_WID-1:0] RESET_PC   = '0,
  parameter int                  IMEM_BYTES = 2048
) (
  input logic               i_clk,
  input logic               i_rst_n,
  fetch_pc_ctrl_if.master   bus
);

  typedef enum logic [1:0] {ST_RUN, ST_RET_WAIT, ST_HALT, ST_ERR} state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;
  localparam logic [DATA_WID:0] IMEM_LIMIT = (DATA_WID+1)'(IMEM_BYTES);

  state_t              r_state, w_state_nx;
  logic [DATA_WID-1:0] r_pc, w_pc_nx;
  logic [3:0]          r_d_icode, r_d_ifun, r_d_rA, r_d_rB;
  logic [3:0]          w_d_icode, w_d_ifun, w_d_rA, w_d_rB;
  logic [DATA_WID-1:0] r_d_valC, r_d_valP, w_d_valC, w_d_valP;
  logic [2:0]          r_d_stat, w_d_stat;
  logic                r_d_valid, w_d_valid;

  logic [3:0]          w_len;
  logic [DATA_WID-1:0] w_valp;
  logic [DATA_WID-1:0] w_pred_pc;
  logic [DATA_WID:0]   w_end;
  logic                w_adr_err;
  logic                w_ins_err;
  logic [2:0]          w_stat;

  always_comb begin
    case (bus.im_icode)
      4'h0, 4'h1, 4'h9:       w_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: w_len = 4'd2;
      4'h7, 4'h8:             w_len = 4'd9;
      4'h3, 4'h4, 4'h5:       w_len = 4'd10;
      default:                w_len = 4'd1;
    endcase
  end

  assign w_valp = r_pc + {{(DATA_WID-4){1'b0}}, w_len};
  // One extra bit so a PC near the top of the address space cannot wrap past the limit check.
  assign w_end     = {1'b0, r_pc} + {{(DATA_WID-3){1'b0}}, w_len};
  assign w_adr_err = (w_end > IMEM_LIMIT);
  assign w_pred_pc = (bus.im_icode == 4'h7 || bus.im_icode == 4'h8) ? bus.im_valC : w_valp;

`ifdef INSTR_VALID_CHECK_EN
  assign w_ins_err = (bus.im_icode > 4'hB);
`else
  assign w_ins_err = 1'b0;
`endif

  // Address error outranks illegal instruction.
  assign w_stat = w_adr_err ? STAT_ADR :
                  w_ins_err ? STAT_INS :
                  (bus.im_icode == 4'h0) ? STAT_HLT : STAT_AOK;

  // PC and state: mispredict > return address > stall_f > state rule > prediction.
  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    if (bus.mispredict) begin
      w_pc_nx    = bus.mispredict_pc;
      w_state_nx = ST_RUN;
    end else if (r_state == ST_RET_WAIT && bus.ret_valid) begin
      w_pc_nx    = bus.ret_pc;
      w_state_nx = ST_RUN;
    end else if (!bus.stall_f && r_state == ST_RUN) begin
      // Halt, ret and errors freeze the PC on the causing instruction.
      if (w_adr_err || w_ins_err)     w_state_nx = ST_ERR;
      else if (bus.im_icode == 4'h0)  w_state_nx = ST_HALT;
      else if (bus.im_icode == 4'h9)  w_state_nx = ST_RET_WAIT;
      else                            w_pc_nx    = w_pred_pc;
    end
  end

  // F/D register: bubble > hold > load; only RUN has a real instruction to hand on.
  always_comb begin
    w_d_icode = r_d_icode;
    w_d_ifun  = r_d_ifun;
    w_d_rA    = r_d_rA;
    w_d_rB    = r_d_rB;
    w_d_valC  = r_d_valC;
    w_d_valP  = r_d_valP;
    w_d_stat  = r_d_stat;
    w_d_valid = r_d_valid;
    if (bus.mispredict || bus.bubble_d || (!bus.stall_d && r_state != ST_RUN)) begin
      w_d_icode = 4'h1;
      w_d_ifun  = 4'h0;
      w_d_rA    = 4'hF;
      w_d_rB    = 4'hF;
      w_d_valC  = '0;
      w_d_valP  = '0;
      w_d_stat  = STAT_AOK;
      w_d_valid = 1'b0;
    end else if (!bus.stall_d) begin
      w_d_icode = bus.im_icode;
      w_d_ifun  = bus.im_ifun;
      w_d_rA    = bus.im_rA;
      w_d_rB    = bus.im_rB;
      w_d_valC  = bus.im_valC;
      w_d_valP  = w_valp;
      w_d_stat  = w_stat;
      w_d_valid = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_RUN;
      r_pc      <= RESET_PC;
      r_d_icode <= 4'h1;
      r_d_ifun  <= 4'h0;
      r_d_rA    <= 4'hF;
      r_d_rB    <= 4'hF;
      r_d_valC  <= '0;
      r_d_valP  <= '0;
      r_d_stat  <= STAT_AOK;
      r_d_valid <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_pc      <= w_pc_nx;
      r_d_icode <= w_d_icode;
      r_d_ifun  <= w_d_ifun;
      r_d_rA    <= w_d_rA;
      r_d_rB    <= w_d_rB;
      r_d_valC  <= w_d_valC;
      r_d_valP  <= w_d_valP;
      r_d_stat  <= w_d_stat;
      r_d_valid <= w_d_valid;
    end
  end

  assign bus.f_pc    = r_pc;
  assign bus.d_icode = r_d_icode;
  assign bus.d_ifun  = r_d_ifun;
  assign bus.d_rA    = r_d_rA;
  assign bus.d_rB    = r_d_rB;
  assign bus.d_valC  = r_d_valC;
  assign bus.d_valP  = r_d_valP;
  assign bus.d_stat  = r_d_stat;
  assign bus.d_valid = r_d_valid;

endmodule

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

Y86-64 fetch-stage controller: owns the program counter, drives it to the combinational instruction memory, consumes the decoded fields (icode/ifun/rA/rB/valC), computes instruction length and predicted next PC, and loads the F/D pipeline register. It sits directly upstream of the instruction memory (PC out) and directly downstream of it (fields in), and feeds the decode stage. It also applies branch-mispredict and return-address corrections, and tracks halt/error state.

## Interface
- DATA_WID, 64, datapath/PC width
- RESET_PC, 0, PC value after reset
- IMEM_BYTES, 2048, instruction memory size in bytes; fetches beyond it are address errors
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- f_pc  output  DATA_WID  current fetch PC to instruction memory
- im_icode, im_ifun, im_rA, im_rB  input  4 each  fields returned for f_pc
- im_valC  input  DATA_WID  constant returned for f_pc (memory already selects the PC+1 source for jXX/call)
- stall_f  input  1  hold PC
- stall_d  input  1  hold F/D register
- bubble_d  input  1  load bubble into F/D register
- mispredict  input  1  taken-predicted jXX resolved not-taken
- mispredict_pc  input  DATA_WID  fall-through address (valP of that jXX)
- ret_valid  input  1  return address available from writeback
- ret_pc  input  DATA_WID  return address
- d_icode, d_ifun, d_rA, d_rB  output  4 each  registered fields
- d_valC, d_valP  output  DATA_WID  registered constant and PC+length
- d_stat  output  3  1=AOK, 2=HLT, 3=ADR, 4=INS
- d_valid  output  1  0 = bubble

## Operation
- Length by icode: 0 halt/1 nop/9 ret -> 1; 2 rrmovq/6 OPq/A pushq/B popq -> 2; 7 jXX/8 call -> 9; 3 irmovq/4 rmmovq/5 mrmovq -> 10. valP = f_pc + length, DATA_WID-bit wraparound.
- Predicted PC: jXX and call -> im_valC; all others -> valP.
- FSM states: RUN, RET_WAIT, HALT, ERR.
- RUN: fetch normally. On ret fetched -> RET_WAIT. On halt fetched -> HALT, d_stat=HLT. On f_pc+length > IMEM_BYTES -> ERR, d_stat=ADR (ADR outranks INS).
- RET_WAIT: PC held, bubbles into D; on ret_valid, PC<=ret_pc, -> RUN.
- HALT/ERR: PC frozen, bubbles into D; exit only by reset or mispredict.
- PC update priority: mispredict (PC<=mispredict_pc, FSM->RUN, D<=bubble) > ret_valid in RET_WAIT > stall_f (hold) > state rule > predicted PC.
- F/D priority: reset > mispredict or bubble_d (bubble) > stall_d (hold) > load fetched instruction (or bubble in RET_WAIT/HALT/ERR after the causing instruction).
- Bubble: icode=1, ifun=0, rA=rB=F, valC=valP=0, d_stat=AOK, d_valid=0.

## Timing
- Reset (async assert, sync release at next clk): f_pc=RESET_PC, F/D=bubble, FSM=RUN.
- Fetch fields are combinational on f_pc in the same cycle; F/D and PC update on the same rising edge: one-cycle fetch latency.
- ret: instruction enters D on edge N; bubbles from N+1 until the edge on which ret_valid is sampled; first return-target instruction reaches D one edge later.
- mispredict: takes effect on the sampling edge; correct-path instruction reaches D next edge; overrides HALT/ERR entered on the wrong path.
- stall_f and stall_d held together freeze PC and D indefinitely with no state change.
- Reset mid-RET_WAIT/HALT discards all pending state.

## Configuration
- INSTR_VALID_CHECK_EN: defined -> icode > B loads with d_stat=INS and FSM->ERR. Undefined -> icode > B treated as 1-byte nop, d_stat=AOK, no state change.

## Test plan
- Reset with RESET_PC=0x40, release -> f_pc=0x40, d_valid=0, d_icode=1, d_stat=1.
- irmovq at 0x0, then OPq -> d_valP=0x0A, next f_pc=0x0A; after OPq f_pc=0x0C.
- call at 0x10, valC=0x100 -> f_pc=0x100; ret at 0x100 -> bubbles until ret_valid with ret_pc=0x19, then f_pc=0x19.
- jXX at 0x20, valC=0x80, then mispredict with mispredict_pc=0x29 while halt fetched at 0x80 -> f_pc=0x29, FSM RUN, no HLT in D.
- nop at IMEM_BYTES-1 then rrmovq at IMEM_BYTES-1 -> d_stat=3, PC frozen; icode=0xC with INSTR_VALID_CHECK_EN -> d_stat=4, without -> d_stat=1, valP=PC+1.
- stall_f+stall_d for 3 cycles during RUN -> f_pc and all d_* outputs unchanged; bubble_d+stall_d together -> bubble.
